// File: rtl/cpu_pkg.sv
// cpu_pkg: formatter state encodings and ASCII constants shared with lcd_display
package cpu_pkg;
  typedef enum logic [2:0] {IDLE, ABS, SHIFT, FORMAT, DONE} state_t;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
endpackage

// File: rtl/bin_to_dec_ascii_if.sv
// bin_to_dec_ascii_if: start/done handshake and formatted result bundle
interface bin_to_dec_ascii_if #(parameter int WIDTH = 16, parameter int DIGITS = 5);
  logic start;
  logic [WIDTH-1:0] value;
  logic busy;
  logic done;
  logic [7:0] sign_char;
  logic [8*DIGITS-1:0] digits;
  modport master(output start, value, input busy, done, sign_char, digits);
  modport slave(input start, value, output busy, done, sign_char, digits);
endinterface

// File: rtl/bin_to_dec_ascii_dabble_adjust.sv
// dabble_adjust: add-3 correction applied to one BCD digit before each shift
module dabble_adjust (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = d >= 4'd5 ? d + 4'd3 : d;
endmodule

// File: rtl/bin_to_dec_ascii.sv
// bin_to_dec_ascii: iterative double-dabble binary to sign + ASCII decimal formatter
// BIN_TO_DEC_BLANK_EN replaces leading zero digits with spaces
module bin_to_dec_ascii
  import cpu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 1
) (
  input logic clk,
  input logic reset,
  bin_to_dec_ascii_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
`ifdef BIN_TO_DEC_BLANK_EN
  localparam logic [8*DIGITS-1:0] RST_DIG = {{(DIGITS-1){ASCII_SPACE}}, ASCII_ZERO};
`else
  localparam logic [8*DIGITS-1:0] RST_DIG = {DIGITS{ASCII_ZERO}};
`endif
  state_t state, next;
  logic [WIDTH-1:0] mag;
  logic [4*DIGITS-1:0] bcd, adj;
  logic [CW-1:0] cnt;
  logic neg, neg_n, busy, busy_n, done, done_n;
  logic [7:0] sign_char, fmt_sign;
  logic [8*DIGITS-1:0] digits, fmt_dig, fmt_n;
`ifdef BIN_TO_DEC_BLANK_EN
  logic lead;
`endif
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    dabble_adjust u_adj (.d(bcd[4*g+:4]), .q(adj[4*g+:4]));
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : next;
  always_comb begin
    next = state == IDLE   ? (bus.start ? ABS : IDLE) :
           state == ABS    ? SHIFT :
           state == SHIFT  ? (cnt == CW'(WIDTH-1) ? FORMAT : SHIFT) :
           state == FORMAT ? DONE : IDLE;
  end
  always_comb begin
    busy_n = next != IDLE;
    done_n = state == DONE;
    neg_n  = SIGNED != 0 && mag[WIDTH-1];
  end
  // leading digits stay blank until the first nonzero nibble; the LS digit always prints
  always_comb begin
`ifdef BIN_TO_DEC_BLANK_EN
    lead = 1'b1;
`endif
    fmt_n = '0;
    for (int i = DIGITS-1; i >= 0; i--) begin
`ifdef BIN_TO_DEC_BLANK_EN
      lead = lead && bcd[4*i+:4] == 4'd0 && i != 0;
      fmt_n[8*i+:8] = lead ? ASCII_SPACE : ASCII_ZERO + {4'h0, bcd[4*i+:4]};
`else
      fmt_n[8*i+:8] = ASCII_ZERO + {4'h0, bcd[4*i+:4]};
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mag       <= '0;
      bcd       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fmt_sign  <= ASCII_SPACE;
      fmt_dig   <= RST_DIG;
      sign_char <= ASCII_SPACE;
      digits    <= RST_DIG;
    end else begin
      busy <= busy_n;
      done <= done_n;
      if (state == IDLE && bus.start) mag <= bus.value;
      if (state == ABS) begin
        neg <= neg_n;
        mag <= neg_n ? -mag : mag;
        bcd <= '0;
        cnt <= '0;
      end
      if (state == SHIFT) begin
        {bcd, mag} <= {adj, mag} << 1;
        cnt <= cnt + 1'b1;
      end
      if (state == FORMAT) begin
        fmt_sign <= neg ? ASCII_MINUS : ASCII_SPACE;
        fmt_dig  <= fmt_n;
      end
      if (state == DONE) begin
        sign_char <= fmt_sign;
        digits    <= fmt_dig;
      end
    end
  end
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.sign_char = sign_char;
  assign bus.digits    = digits;
endmodule

// File: tb/tb_bin_to_dec_ascii.sv
// tb_bin_to_dec_ascii: signed and unsigned formatters driven in parallel against an arithmetic scoreboard
module tb_bin_to_dec_ascii;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [15:0] value = '0;
  int passed = 0, total = 0, fails = 0;
  logic [47:0] qs[$], qu[$];
  logic [47:0] last_s, last_u;
`ifdef BIN_TO_DEC_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam logic [39:0] RST_DIG = BLANK ? 40'h2020202030 : 40'h3030303030;
  localparam logic [47:0] RST = {8'h20, RST_DIG};
  bin_to_dec_ascii_if sif();
  bin_to_dec_ascii_if uif();
  assign sif.start = start;
  assign sif.value = value;
  assign uif.start = start;
  assign uif.value = value;
  bin_to_dec_ascii #(.WIDTH(16), .DIGITS(5), .SIGNED(1)) ds (.clk(clk), .reset(reset), .bus(sif));
  bin_to_dec_ascii #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) du (.clk(clk), .reset(reset), .bus(uif));
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  function automatic logic [47:0] model(input logic [15:0] v, input bit sgn);
    bit neg;
    int unsigned t;
    logic [39:0] r;
    neg = sgn && v[15];
    t = neg ? 32'(65536 - int'(v)) : 32'(v);
    for (int i = 0; i < 5; i++) begin
      r[8*i+:8] = (BLANK && i > 0 && t == 0) ? 8'h20 : 8'h30 + 8'(t % 10);
      t = t / 10;
    end
    return {neg ? 8'h2D : 8'h20, r};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [15:0] v);
    @(negedge clk);
    start = 1'b1;
    value = v;
    qs.push_back(model(v, 1'b1));
    qu.push_back(model(v, 1'b0));
    @(posedge clk);
    #1;
    start = 1'b0;
    value = 16'($urandom);
    chk("busy_after_accept", {sif.busy, uif.busy}, 2'b11);
  endtask
  task automatic check_out(input string tag);
    logic [47:0] e;
    chk({tag, "_busy_low"}, {sif.busy, uif.busy}, 2'b00);
    if (qs.size() > 0) begin
      e = qs.pop_front();
      chk({tag, "_signed"}, {sif.sign_char, sif.digits}, e);
      last_s = e;
    end
    if (qu.size() > 0) begin
      e = qu.pop_front();
      chk({tag, "_unsigned"}, {uif.sign_char, uif.digits}, e);
      last_u = e;
    end
  endtask
  task automatic wait_done(input string tag);
    int lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      if (k == 10) begin
        chk({tag, "_hold_s"}, {sif.sign_char, sif.digits}, last_s);
        chk({tag, "_hold_u"}, {uif.sign_char, uif.digits}, last_u);
      end
      if (sif.done) begin
        lat = k;
        chk({tag, "_udone"}, uif.done, 1'b1);
      end
    end
    chk({tag, "_latency"}, lat, 19);
    if (lat > 0) begin
      check_out(tag);
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, {sif.done, uif.done}, 2'b00);
    end
  endtask
  initial begin
    int dn, lat;
    last_s = RST;
    last_u = RST;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_s", {sif.busy, sif.done, sif.sign_char, sif.digits}, {2'b00, RST});
    chk("reset_u", {uif.busy, uif.done, uif.sign_char, uif.digits}, {2'b00, RST});
    @(negedge clk);
    reset = 1'b0;
    go(16'h0000); wait_done("zero");
    go(16'd12345); wait_done("pos12345");
    go(16'hFFFF); wait_done("ffff");
    go(16'h8000); wait_done("min8000");
    go(16'd7); wait_done("seven");
    go(16'h0000); wait_done("zero2");
    go(16'hFFD8); wait_done("neg40");
    go(16'd100);
    dn = 0;
    lat = -1;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      start = (k == 5 || k == 19);
      value = 16'd999;
      @(posedge clk);
      #1;
      if (sif.done) begin
        dn++;
        lat = k;
      end
    end
    start = 1'b0;
    chk("hs_done_count", dn, 1);
    chk("hs_latency", lat, 19);
    check_out("hs100");
    go(16'd999); wait_done("hs999");
    go(16'd4321);
    void'(qs.pop_back());
    void'(qu.pop_back());
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_s", {sif.busy, sif.done, sif.sign_char, sif.digits}, {2'b00, RST});
    chk("abort_u", {uif.busy, uif.done, uif.sign_char, uif.digits}, {2'b00, RST});
    @(negedge clk);
    start = 1'b1;
    value = 16'd55;
    @(posedge clk);
    #1;
    chk("reset_beats_start", {sif.busy, uif.busy}, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    dn = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (sif.done || uif.done) dn++;
    end
    chk("abort_no_done", dn, 0);
    last_s = RST;
    last_u = RST;
    repeat (3) begin
      go(16'($urandom_range(0, 65535)));
      wait_done("random");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
